// File: rtl/inv_row_shift_round.sv
// Inverse AES round tail: AddRoundKey, optional InvMixColumns (one column per
// cycle), then InvShiftRows applied combinationally on the output side.
// One transaction in flight at a time; the result is held until out_ready.
module inv_row_shift_round (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         mix_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [1:0]   col_cnt_q, col_cnt_d;
    logic         mix_en_q, mix_en_d;

    logic [31:0]  work_col [4];
    logic [31:0]  sel_col;
    logic [31:0]  mixed_col;

    // GF(2^8) multiply by x, reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one column; byte [31:24] is row 0.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a   [4];
        logic [7:0] x2  [4];
        logic [7:0] x4  [4];
        logic [7:0] x8  [4];
        logic [7:0] m9  [4];
        logic [7:0] mb  [4];
        logic [7:0] md  [4];
        logic [7:0] me  [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Split the working state into its four columns for the mix datapath.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cols
            assign work_col[gi] = work_q[127-32*gi -: 32];
        end
    endgenerate

    assign sel_col   = work_col[col_cnt_q];
    assign mixed_col = inv_mix_col(sel_col);

    // InvShiftRows: out col c, row r takes work col (c-r) mod 4, row r.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_shift
            localparam int C   = gi / 4;
            localparam int R   = gi % 4;
            localparam int SRC = ((C - R + 4) % 4) * 4 + R;
            assign out_data[127-8*gi -: 8] = work_q[127-8*SRC -: 8];
        end
    endgenerate

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);

    // Next-state and datapath update: accept, mix one column per cycle, hold.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        col_cnt_d = col_cnt_q;
        mix_en_d  = mix_en_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    work_d    = in_state ^ in_key;
                    mix_en_d  = mix_en;
                    col_cnt_d = 2'd0;
                    state_d   = mix_en ? MIX : DONE;
                end
            end
            MIX: begin
                // MIX is only entered with mix_en captured high; the guard
                // keeps a stray entry from corrupting the held state.
                if (mix_en_q) begin
                    for (int i = 0; i < 4; i++) begin
                        if (col_cnt_q == i[1:0]) begin
                            work_d[127-32*i -: 32] = mixed_col;
                        end
                    end
                end
                col_cnt_d = col_cnt_q + 2'd1;
                if (col_cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset wins over any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            work_q    <= 128'h0;
            col_cnt_q <= 2'd0;
            mix_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            col_cnt_q <= col_cnt_d;
            mix_en_q  <= mix_en_d;
        end
    end

endmodule

// File: tb/tb_inv_row_shift_round.sv
// Bench for inv_row_shift_round: fixed vector table, reset corner cases and
// randomized transactions compared against a byte-array reference model.
module tb_inv_row_shift_round;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         mix_en;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int checks;
    int errors;

    inv_row_shift_round dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .mix_en    (mix_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] st;
        logic [127:0] key;
        logic         mix;
        logic [127:0] exp;
        int           lat;
        int           hold;
    } vec_t;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply modulo 0x11B.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic       hi;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            hi = aa[7];
            aa = aa << 1;
            if (hi) aa = aa ^ 8'h1b;
        end
        return p;
    endfunction

    // Reference: AddRoundKey, matrix multiply per column, row rotation.
    function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key,
                                           input logic mix);
        logic [127:0] x;
        logic [127:0] res;
        logic [7:0]   w    [4][4];
        logic [7:0]   m    [4][4];
        logic [7:0]   base [4];
        base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
        x = st ^ key;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w[c][r] = x[127-32*c-8*r -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (mix) begin
                    m[c][r] = 8'h00;
                    for (int j = 0; j < 4; j++)
                        m[c][r] = m[c][r] ^ gf_mul(base[(j - r + 4) % 4], w[c][j]);
                end else begin
                    m[c][r] = w[c][r];
                end
            end
        res = 128'h0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-32*c-8*r -: 8] = m[(c - r + 4) % 4][r];
        return res;
    endfunction

    // One full transaction: accept, wait for result, backpressure, release.
    task automatic run_txn(input int id, input logic [127:0] st, input logic [127:0] key,
                           input logic mix, input logic [127:0] exp, input int exp_lat,
                           input int hold);
        int lat;
        logic [127:0] held;
        @(negedge clk);
        in_valid = 1'b1;
        in_state = st;
        in_key   = key;
        mix_en   = mix;
        out_ready = 1'($urandom_range(0, 1));
        check("accept_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            // Post-acceptance input changes and busy-time in_valid must be ignored.
            in_valid  = 1'($urandom_range(0, 1));
            in_state  = {$urandom, $urandom, $urandom, $urandom};
            in_key    = {$urandom, $urandom, $urandom, $urandom};
            mix_en    = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            check("busy_in_ready", 128'(in_ready), 128'(0));
        end while (!out_valid && lat < 20);
        check("latency", 128'(lat), 128'(exp_lat));
        check("out_data", out_data, exp);
        held = out_data;
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_valid", 128'(out_valid), 128'(1));
            check("hold_data", out_data, held);
            check("hold_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 128'(out_valid), 128'(0));
        check("release_in_ready", 128'(in_ready), 128'(1));
        $display("txn %0d mix=%0b lat=%0d hold=%0d out=%h exp=%h", id, mix, lat, hold, held, exp);
    endtask

    vec_t vecs [6];
    logic [127:0] rs;
    logic [127:0] rk;
    logic         rm;
    int           rh;

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = 128'h0;
        in_key    = 128'h0;
        mix_en    = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h0, 1'b0,
                    128'h000d0a07_04010e0b_0805020f_0c090603, 1, 0};
        vecs[1] = '{{4{32'h8e4da1bc}}, 128'h0, 1'b1, {4{32'hdb135345}}, 5, 10};
        vecs[2] = '{128'h01234567_89abcdef_fedcba98_76543210,
                    128'h01234567_89abcdef_fedcba98_76543210, 1'b1, 128'h0, 5, 1};
        vecs[3] = '{{4{32'h8e4da1bc}}, 128'h0, 1'b0, {4{32'h8e4da1bc}}, 1, 2};
        vecs[4] = '{128'h0, {4{32'h8e4da1bc}}, 1'b1, {4{32'hdb135345}}, 5, 0};
        vecs[5] = '{{4{32'hffffffff}}, {4{32'hffffffff}}, 1'b0, 128'h0, 1, 3};

        // Reset state, including in_ready held low while rst is high.
        repeat (2) @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 128'(in_ready), 128'(1));
        check("post_rst_out_valid", 128'(out_valid), 128'(0));

        for (int i = 0; i < 6; i++)
            run_txn(i, vecs[i].st, vecs[i].key, vecs[i].mix, vecs[i].exp, vecs[i].lat, vecs[i].hold);

        // Reset on the second MIX edge aborts the transaction.
        @(negedge clk);
        in_valid = 1'b1;
        in_state = {4{32'h8e4da1bc}};
        in_key   = 128'h0;
        mix_en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_ready_rst", 128'(in_ready), 128'(0));
        check("abort_out_valid", 128'(out_valid), 128'(0));
        check("abort_out_data", out_data, 128'h0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("abort_no_valid", 128'(out_valid), 128'(0));
            check("abort_in_ready", 128'(in_ready), 128'(1));
        end
        $display("txn abort mid-mix done");
        run_txn(100, {4{32'h8e4da1bc}}, 128'h0, 1'b1, {4{32'hdb135345}}, 5, 0);

        // Randomized transactions against the reference model.
        for (int t = 0; t < 1000; t++) begin
            rs = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            rm = 1'($urandom_range(0, 1));
            rh = $urandom_range(0, 2);
            run_txn(1000 + t, rs, rk, rm, model(rs, rk, rm), rm ? 5 : 1, rh);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
